// File: rtl/l2_cache_wb_if.sv
// l2_cache_wb_if: L1-side request/response and memory-side block handshake of l2_cache_wb.
interface l2_cache_wb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int BLOCK_SIZE = 32,
  parameter int CNT_WIDTH  = 16
);
  logic [ADDR_WIDTH-1:0]            l1_addr;
  logic [BLOCK_SIZE*DATA_WIDTH-1:0] l1_data_in;
  logic                             l1_read;
  logic                             l1_write;
  logic                             l1_ready;
  logic                             l1_hit;
  logic                             l1_block_valid;
  logic [BLOCK_SIZE*DATA_WIDTH-1:0] l1_block_data_out;
  logic [ADDR_WIDTH-1:0]            mem_addr;
  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_out;
  logic                             mem_read;
  logic                             mem_write;
  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_block;
  logic                             mem_ready;
  logic [CNT_WIDTH-1:0]             hit_count;
  logic [CNT_WIDTH-1:0]             miss_count;
  logic [CNT_WIDTH-1:0]             wb_count;
  modport slave (
    input  l1_addr, l1_data_in, l1_read, l1_write, mem_data_block, mem_ready,
    output l1_ready, l1_hit, l1_block_valid, l1_block_data_out,
           mem_addr, mem_data_out, mem_read, mem_write, hit_count, miss_count, wb_count
  );
  modport master (
    output l1_addr, l1_data_in, l1_read, l1_write, mem_data_block, mem_ready,
    input  l1_ready, l1_hit, l1_block_valid, l1_block_data_out,
           mem_addr, mem_data_out, mem_read, mem_write, hit_count, miss_count, wb_count
  );
endinterface

// File: rtl/l2_cache_wb.sv
// l2_cache_wb: set-associative block L2 cache with selectable write-back/write-through,
// true-LRU replacement, dirty-victim eviction and saturating perf counters.
module l2_cache_wb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int CACHE_SIZE = 512,
  parameter int BLOCK_SIZE = 32,
  parameter int NUM_WAYS   = 4,
  parameter bit WRITE_BACK = 1'b1,
  parameter int CNT_WIDTH  = 16
) (
  input logic          clk,
  input logic          rst,
  l2_cache_wb_if.slave bus
);
  localparam int BW    = BLOCK_SIZE * DATA_WIDTH;
  localparam int OFF_W = $clog2(BLOCK_SIZE);
  localparam int SETS  = CACHE_SIZE / BLOCK_SIZE / NUM_WAYS;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - OFF_W - IDX_W;
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic [2:0] {IDLE, LOOKUP, TAG_CHECK, EVICT, FILL, MEM_WR} state_t;
  state_t state_q, state_n, miss_n;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [BW-1:0]    req_data;
  logic             req_wr;
  logic             hit_q, vdirty_q;
  logic [WAY_W-1:0] way_q;

  logic             valid_q [SETS][NUM_WAYS];
  logic             dirty_q [SETS][NUM_WAYS];
  logic [TAG_W-1:0] tag_q   [SETS][NUM_WAYS];
  logic [WAY_W-1:0] age_q   [SETS][NUM_WAYS];
  logic [BW-1:0]    data_q  [SETS][NUM_WAYS];

  logic             hit_c, inv_c;
  logic [WAY_W-1:0] hit_way, inv_way, lru_way;
  logic             done, install, line_wr, touch;
  logic [BW-1:0]    line_data;

  // Descending scan so the lowest-index invalid way wins
  always_comb begin
    hit_c   = 1'b0;
    inv_c   = 1'b0;
    hit_way = '0;
    inv_way = '0;
    lru_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
        hit_c   = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[req_idx][w]) begin
        inv_c   = 1'b1;
        inv_way = WAY_W'(w);
      end
      if (age_q[req_idx][w] == WAY_W'(NUM_WAYS - 1)) lru_way = WAY_W'(w);
    end
  end

  always_comb begin
    miss_n  = !req_wr ? FILL : WRITE_BACK ? IDLE : MEM_WR;
    state_n = state_q;
    unique case (state_q)
      IDLE:        if (bus.l1_read || bus.l1_write) state_n = LOOKUP;
      LOOKUP:      state_n = TAG_CHECK;
      TAG_CHECK:   state_n = hit_q ? ((req_wr && !WRITE_BACK) ? MEM_WR : IDLE) : vdirty_q ? EVICT : miss_n;
      EVICT:       if (bus.mem_ready) state_n = miss_n;
      FILL, MEM_WR: if (bus.mem_ready) state_n = IDLE;
      default:     state_n = IDLE;
    endcase
  end

  // Every return to IDLE completes a request; all but a tag-check hit install a line
  assign done      = state_q != IDLE && state_n == IDLE;
  assign install   = done && !(state_q == TAG_CHECK && hit_q);
  assign line_wr   = install || (state_q == TAG_CHECK && hit_q && req_wr && WRITE_BACK);
  assign touch     = install || (state_q == TAG_CHECK && hit_q);
  assign line_data = state_q == FILL ? bus.mem_data_block : req_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_tag               <= '0;
      req_idx               <= '0;
      req_data              <= '0;
      req_wr                <= 1'b0;
      hit_q                 <= 1'b0;
      vdirty_q              <= 1'b0;
      way_q                 <= '0;
      bus.l1_ready          <= 1'b0;
      bus.l1_hit            <= 1'b0;
      bus.l1_block_valid    <= 1'b0;
      bus.l1_block_data_out <= '0;
      bus.hit_count         <= '0;
      bus.miss_count        <= '0;
      bus.wb_count          <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          age_q[s][w]   <= WAY_W'(w);
        end
    end else begin
      bus.l1_ready       <= done;
      bus.l1_block_valid <= done;
      if (done) begin
        bus.l1_hit            <= hit_q;
        bus.l1_block_data_out <= state_q == FILL ? bus.mem_data_block : req_wr ? req_data : data_q[req_idx][way_q];
      end
      if (state_q == IDLE && (bus.l1_read || bus.l1_write)) begin
        {req_tag, req_idx} <= bus.l1_addr[ADDR_WIDTH-1:OFF_W];
        req_data           <= bus.l1_data_in;
        req_wr             <= bus.l1_write && !bus.l1_read;
      end
      if (state_q == LOOKUP) begin
        hit_q    <= hit_c;
        way_q    <= hit_c ? hit_way : inv_c ? inv_way : lru_way;
        vdirty_q <= !hit_c && !inv_c && dirty_q[req_idx][lru_way];
      end
      if (state_q == TAG_CHECK && hit_q)
        bus.hit_count <= bus.hit_count + CNT_WIDTH'(bus.hit_count != CNT_MAX);
      if (state_q == TAG_CHECK && !hit_q)
        bus.miss_count <= bus.miss_count + CNT_WIDTH'(bus.miss_count != CNT_MAX);
      if (state_q == EVICT && bus.mem_ready) begin
        bus.wb_count            <= bus.wb_count + CNT_WIDTH'(bus.wb_count != CNT_MAX);
        dirty_q[req_idx][way_q] <= 1'b0;
      end
      if (line_wr) begin
        valid_q[req_idx][way_q] <= 1'b1;
        tag_q[req_idx][way_q]   <= req_tag;
        dirty_q[req_idx][way_q] <= WRITE_BACK && req_wr;
      end
      // Ages younger than the accessed way shift up by one, keeping a permutation
      if (touch)
        for (int w = 0; w < NUM_WAYS; w++)
          if (WAY_W'(w) == way_q) age_q[req_idx][w] <= '0;
          else if (age_q[req_idx][w] < age_q[req_idx][way_q]) age_q[req_idx][w] <= age_q[req_idx][w] + WAY_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (line_wr) data_q[req_idx][way_q] <= line_data;
  end

  always_comb begin
    bus.mem_read     = state_q == FILL;
    bus.mem_write    = state_q == EVICT || state_q == MEM_WR;
    bus.mem_addr     = state_q == EVICT ? {tag_q[req_idx][way_q], req_idx, {OFF_W{1'b0}}} :
                       (state_q == FILL || state_q == MEM_WR) ? {req_tag, req_idx, {OFF_W{1'b0}}} : '0;
    bus.mem_data_out = state_q == EVICT ? data_q[req_idx][way_q] : state_q == MEM_WR ? req_data : '0;
  end
endmodule

// File: tb/tb_l2_cache_wb.sv
// tb_l2_cache_wb: scoreboard bench for l2_cache_wb across write-back, write-through and
// 4-bit-counter builds sharing one stimulus path selected by sel.
module tb_l2_cache_wb;
  localparam int BW = 1024;

  typedef struct packed {logic hit; logic [BW-1:0] data;} rsp_t;
  typedef struct packed {logic wr; logic [10:0] addr; logic [BW-1:0] data;} mem_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   sel = 0;
  logic [10:0]   t_addr = '0;
  logic [BW-1:0] t_data = '0, t_mdata = '0;
  logic t_rd = 1'b0, t_wr = 1'b0, t_mrdy = 1'b0;

  rsp_t rspq[$];
  mem_t memq[$];
  int checks = 0, fails = 0, mem_lat = 3, k = 0;
  rsp_t r;
  mem_t m;

  always #5 clk = ~clk;

  l2_cache_wb_if ia ();
  l2_cache_wb_if ib ();
  l2_cache_wb_if #(.CNT_WIDTH(4)) ic ();

  l2_cache_wb u_a (.clk(clk), .rst(rst), .bus(ia));
  l2_cache_wb #(.WRITE_BACK(1'b0)) u_b (.clk(clk), .rst(rst), .bus(ib));
  l2_cache_wb #(.CNT_WIDTH(4)) u_c (.clk(clk), .rst(rst), .bus(ic));

  assign ia.l1_addr = t_addr;  assign ib.l1_addr = t_addr;  assign ic.l1_addr = t_addr;
  assign ia.l1_data_in = t_data;  assign ib.l1_data_in = t_data;  assign ic.l1_data_in = t_data;
  assign ia.mem_data_block = t_mdata;  assign ib.mem_data_block = t_mdata;  assign ic.mem_data_block = t_mdata;
  assign ia.l1_read = t_rd && sel == 0;  assign ib.l1_read = t_rd && sel == 1;  assign ic.l1_read = t_rd && sel == 2;
  assign ia.l1_write = t_wr && sel == 0;  assign ib.l1_write = t_wr && sel == 1;  assign ic.l1_write = t_wr && sel == 2;
  assign ia.mem_ready = t_mrdy && sel == 0;  assign ib.mem_ready = t_mrdy && sel == 1;  assign ic.mem_ready = t_mrdy && sel == 2;

  logic o_ready, o_hit, o_bv, o_mrd, o_mwr;
  logic [BW-1:0] o_data, o_mdout;
  logic [10:0] o_maddr;
  logic [15:0] o_hc, o_mc, o_wc;
  assign o_ready = sel == 0 ? ia.l1_ready : sel == 1 ? ib.l1_ready : ic.l1_ready;
  assign o_hit   = sel == 0 ? ia.l1_hit : sel == 1 ? ib.l1_hit : ic.l1_hit;
  assign o_bv    = sel == 0 ? ia.l1_block_valid : sel == 1 ? ib.l1_block_valid : ic.l1_block_valid;
  assign o_data  = sel == 0 ? ia.l1_block_data_out : sel == 1 ? ib.l1_block_data_out : ic.l1_block_data_out;
  assign o_mrd   = sel == 0 ? ia.mem_read : sel == 1 ? ib.mem_read : ic.mem_read;
  assign o_mwr   = sel == 0 ? ia.mem_write : sel == 1 ? ib.mem_write : ic.mem_write;
  assign o_maddr = sel == 0 ? ia.mem_addr : sel == 1 ? ib.mem_addr : ic.mem_addr;
  assign o_mdout = sel == 0 ? ia.mem_data_out : sel == 1 ? ib.mem_data_out : ic.mem_data_out;
  assign o_hc    = sel == 0 ? ia.hit_count : sel == 1 ? ib.hit_count : 16'(ic.hit_count);
  assign o_mc    = sel == 0 ? ia.miss_count : sel == 1 ? ib.miss_count : 16'(ic.miss_count);
  assign o_wc    = sel == 0 ? ia.wb_count : sel == 1 ? ib.wb_count : 16'(ic.wb_count);

  function automatic logic [BW-1:0] blk(input logic [15:0] s);
    for (int i = 0; i < 32; i++) blk[i*32 +: 32] = {s, 16'(i)};
  endfunction

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic chk_blk(input string n, input logic [BW-1:0] a, input logic [BW-1:0] e);
    int d;
    checks++;
    if (a !== e) begin
      fails++;
      d = 0;
      for (int i = 31; i >= 0; i--) if (a[i*32 +: 32] !== e[i*32 +: 32]) d = i;
      $display("FAIL %s: word %0d got %h expected %h", n, d, a[d*32 +: 32], e[d*32 +: 32]);
    end
  endtask

  task automatic mexp(input logic wr, input logic [10:0] a, input logic [BW-1:0] d);
    mem_t t;
    t.wr = wr; t.addr = a; t.data = d;
    memq.push_back(t);
  endtask

  task automatic req(input logic rd, input logic wr, input logic [10:0] a, input logic [BW-1:0] d,
                     input logic eh, input logic [BW-1:0] ed);
    rsp_t t;
    int n;
    t.hit = eh; t.data = ed;
    rspq.push_back(t);
    t_addr = a; t_data = d; t_rd = rd; t_wr = wr;
    @(posedge clk);
    #1 t_rd = 1'b0; t_wr = 1'b0; t_data = '0; t_addr = '0;
    n = 0;
    while (!o_ready && n < 300) begin
      @(posedge clk);
      #1 n++;
    end
    if (!o_ready) chk("ready_timeout", 64'(n), 64'(300 + 1));
    else if (eh && !(sel == 1 && wr && !rd)) chk("hit_latency", 64'(n), 64'd2);
  endtask

  task automatic do_reset();
    rst = 1'b1; t_rd = 1'b0; t_wr = 1'b0; mem_lat = 3;
    @(posedge clk);
    #1 rspq.delete(); memq.delete();
    chk("reset_outputs", 64'({o_ready, o_hit, o_bv, o_mrd, o_mwr, o_maddr, |{o_hc, o_mc, o_wc}, |o_data, |o_mdout}), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: response scoreboard and memory-side responder/checker
  always @(negedge clk) begin
    if (rst) begin
      k = 0;
      t_mrdy = 1'b0;
    end else begin
      if (o_ready) begin
        if (rspq.size() == 0) chk("unexpected_l1_ready", 64'd1, 64'd0);
        else begin
          r = rspq.pop_front();
          chk("l1_hit", 64'(o_hit), 64'(r.hit));
          chk("l1_block_valid", 64'(o_bv), 64'd1);
          chk_blk("l1_data", o_data, r.data);
        end
      end
      if (t_mrdy) begin
        t_mrdy = 1'b0;
        k = 0;
      end else if (o_mrd || o_mwr) begin
        k++;
        if (o_mrd && o_mwr) chk("mem_strobes_exclusive", 64'd1, 64'd0);
        if (k == mem_lat) begin
          if (memq.size() == 0) begin
            chk("unexpected_mem_access", 64'({o_mwr, o_maddr}), 64'd0);
            t_mdata = '0;
          end else begin
            m = memq.pop_front();
            chk("mem_op_write", 64'(o_mwr), 64'(m.wr));
            chk("mem_addr", 64'(o_maddr), 64'(m.addr));
            if (m.wr) chk_blk("mem_data_out", o_mdout, m.data);
            t_mdata = m.wr ? '0 : m.data;
          end
          t_mrdy = 1'b1;
        end
      end else k = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] ba, bc, bd, be, bf, bx, b1, b2, b3, b4, b5;
    ba = blk(16'hA000); bc = blk(16'hC000); bd = blk(16'hD000); be = blk(16'hE000);
    bf = blk(16'hF000); bx = blk(16'h5A5A); b1 = blk(16'hB001); b2 = blk(16'hB002);
    b3 = blk(16'hB003); b4 = blk(16'hB004); b5 = blk(16'hB005);
    // Read miss then hit
    sel = 0;
    do_reset();
    mexp(1'b0, 11'h020, ba);
    req(1'b1, 1'b0, 11'h020, '0, 1'b0, ba);
    req(1'b1, 1'b0, 11'h020, '0, 1'b1, ba);
    chk("t1_hit_count", 64'(o_hc), 64'd1);
    chk("t1_miss_count", 64'(o_mc), 64'd1);
    // Dirty victim eviction
    do_reset();
    req(1'b0, 1'b1, 11'h0A0, bc, 1'b0, bc);
    mexp(1'b0, 11'h020, ba); req(1'b1, 1'b0, 11'h020, '0, 1'b0, ba);
    mexp(1'b0, 11'h120, b2); req(1'b1, 1'b0, 11'h120, '0, 1'b0, b2);
    mexp(1'b0, 11'h1A0, b3); req(1'b1, 1'b0, 11'h1A0, '0, 1'b0, b3);
    mexp(1'b1, 11'h0A0, bc); mexp(1'b0, 11'h220, b4);
    req(1'b1, 1'b0, 11'h220, '0, 1'b0, b4);
    chk("t2_wb_count", 64'(o_wc), 64'd1);
    mexp(1'b0, 11'h0A0, bc); req(1'b1, 1'b0, 11'h0A0, '0, 1'b0, bc);
    // LRU order
    do_reset();
    mexp(1'b0, 11'h020, ba); req(1'b1, 1'b0, 11'h020, '0, 1'b0, ba);
    mexp(1'b0, 11'h0A0, b1); req(1'b1, 1'b0, 11'h0A0, '0, 1'b0, b1);
    mexp(1'b0, 11'h120, b2); req(1'b1, 1'b0, 11'h120, '0, 1'b0, b2);
    mexp(1'b0, 11'h1A0, b3); req(1'b1, 1'b0, 11'h1A0, '0, 1'b0, b3);
    req(1'b1, 1'b0, 11'h020, '0, 1'b1, ba);
    mexp(1'b0, 11'h220, b4); req(1'b1, 1'b0, 11'h220, '0, 1'b0, b4);
    req(1'b1, 1'b0, 11'h020, '0, 1'b1, ba);
    mexp(1'b0, 11'h0A0, b5); req(1'b1, 1'b0, 11'h0A0, '0, 1'b0, b5);
    chk("t3_wb_count", 64'(o_wc), 64'd0);
    // Write-through build
    sel = 1;
    do_reset();
    mexp(1'b1, 11'h040, bd); req(1'b0, 1'b1, 11'h040, bd, 1'b0, bd);
    mexp(1'b0, 11'h0C0, b1); req(1'b1, 1'b0, 11'h0C0, '0, 1'b0, b1);
    mexp(1'b0, 11'h140, b2); req(1'b1, 1'b0, 11'h140, '0, 1'b0, b2);
    mexp(1'b0, 11'h1C0, b3); req(1'b1, 1'b0, 11'h1C0, '0, 1'b0, b3);
    mexp(1'b1, 11'h0C0, be); req(1'b0, 1'b1, 11'h0C0, be, 1'b1, be);
    mexp(1'b0, 11'h240, bf); req(1'b1, 1'b0, 11'h240, '0, 1'b0, bf);
    req(1'b1, 1'b0, 11'h0C0, '0, 1'b1, be);
    chk("t4_wb_count", 64'(o_wc), 64'd0);
    // Reset during fill
    sel = 0;
    do_reset();
    mem_lat = 100;
    t_addr = 11'h060; t_rd = 1'b1;
    @(posedge clk);
    #1 t_rd = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("t5_fill_mem_read", 64'(o_mrd), 64'd1);
    chk("t5_fill_mem_addr", 64'(o_maddr), 64'h060);
    #2 rst = 1'b1;
    #1 chk("t5_rst_mem_read", 64'(o_mrd), 64'd0);
    chk("t5_rst_outputs", 64'({o_ready, o_mwr, o_maddr, |{o_hc, o_mc, o_wc}}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0; mem_lat = 3; memq.delete(); rspq.delete();
    @(posedge clk);
    #1 mexp(1'b0, 11'h060, b5); req(1'b1, 1'b0, 11'h060, '0, 1'b0, b5);
    chk("t5_miss_count", 64'(o_mc), 64'd1);
    // Counter saturation and read-over-write priority
    sel = 2;
    do_reset();
    mexp(1'b0, 11'h020, ba); req(1'b1, 1'b0, 11'h020, '0, 1'b0, ba);
    for (int i = 0; i < 20; i++) req(1'b1, 1'b0, 11'h020, '0, 1'b1, ba);
    chk("t6_hit_count_sat", 64'(o_hc), 64'd15);
    chk("t6_miss_count", 64'(o_mc), 64'd1);
    req(1'b1, 1'b1, 11'h020, bx, 1'b1, ba);
    req(1'b1, 1'b0, 11'h020, '0, 1'b1, ba);
    chk("t6_hit_count_held", 64'(o_hc), 64'd15);
    repeat (2) @(posedge clk);
    #1 chk("queues_drained", 64'(memq.size() + rspq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
